barrel_rotator_pipe: RTL and testbench
======================================

BARREL_ROTATOR_PIPE -- requirements
Module: barrel_rotator_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 256, operand width; SHALL be a power of two, >= 8.
REQ-002 Parameter SHIFT_BITS, default $clog2(DATA_WIDTH), shift-amount width; SHALL NOT be overridden.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  global advance enable; low freezes the entire pipeline.
REQ-006 in_valid  input  1  input beat valid.
REQ-007 in_ready  output  1  block accepts the input beat this cycle.
REQ-008 mode  input  2  operation: 00 ROTR, 01 ROTL, 10 SHR logical, 11 SAR arithmetic.
REQ-009 a_in  input  DATA_WIDTH  operand.
REQ-010 shift_in  input  SHIFT_BITS  shift/rotate amount, 0..DATA_WIDTH-1.
REQ-011 out_valid  output  1  result beat valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 a_out  output  DATA_WIDTH  result.

Function
REQ-014 Datapath SHALL be a log-stage barrel: stage k (k = 0..SHIFT_BITS-1) applies a shift of 2^k when shift_in bit k is set, with one register bank per stage.
REQ-015 Latency SHALL be exactly SHIFT_BITS cycles from input acceptance to out_valid, absent stalls (8 for DATA_WIDTH=256).
REQ-016 Each stage register SHALL carry valid, mode, residual shift bits, and partial data.
REQ-017 Advance condition: adv = enable && (!out_valid || out_ready); when adv is high, all stages shift one position; otherwise, all stages hold their values.
REQ-018 in_ready SHALL equal adv; a beat is accepted iff in_valid && in_ready.
REQ-019 When adv is high and in_valid is low, a bubble (valid=0) SHALL enter stage 0.
REQ-020 ROTR: bits shifted out of bit 0 SHALL re-enter at bit DATA_WIDTH-1; ROTL: bits leaving the MSB SHALL re-enter at the LSB.
REQ-021 SHR SHALL zero-fill from the MSB; SAR SHALL fill with the operand's original bit DATA_WIDTH-1, captured at acceptance.
REQ-022 shift_in = 0 SHALL return a_in unchanged in all modes.
REQ-023 a_out SHALL be driven only from the final stage register; while out_valid is 0, its value is don't-care.
REQ-024 Back-to-back beats with differing modes and amounts SHALL each produce their own correct result, in order, with no loss or duplication.
REQ-025 Full pipeline with out_ready low: no beat is accepted (in_ready=0), and a_out/out_valid SHALL stay stable until out_ready rises.
REQ-026 enable low SHALL override out_ready: out_valid and a_out stay stable and no beat is consumed.

Reset
REQ-027 When rst_n is low at a clock edge, all stage valid bits and out_valid SHALL clear to 0; data registers are don't-care.
REQ-028 Reset mid-operation SHALL discard all in-flight beats; the first beat accepted after rst_n goes high SHALL emerge after exactly SHIFT_BITS advancing cycles.
REQ-029 in_ready SHALL be low while rst_n is low.

Configuration
REQ-030 Macro BARREL_ROTATOR_ZERO_FLAG_EN: when defined, adds output zero_out (1 bit), registered alongside the final stage, high iff a_out == 0 while out_valid is 1, else 0, reset to 0.
REQ-031 Without BARREL_ROTATOR_ZERO_FLAG_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Verification (DATA_WIDTH=8, latency 3)
REQ-032 ROTR a_in=0x81, shift=1, out_ready=1 -> a_out=0xC0, out_valid exactly 3 cycles after acceptance.
REQ-033 ROTL 0x81 by 1 -> 0x03; SHR 0x80 by 3 -> 0x10; SAR 0x80 by 3 -> 0xF0; SAR 0x70 by 3 -> 0x0E; any mode, shift=0, 0x5A -> 0x5A.
REQ-034 Stream 3 beats, then hold out_ready=0 for 5 cycles -> in_ready=0, a_out holds the first result; after out_ready=1, results emerge in order, one per cycle.
REQ-035 enable=0 for 4 cycles mid-stream -> all outputs frozen, no beats lost or duplicated; the sequence resumes unchanged.
REQ-036 rst_n=0 for 1 cycle with 2 beats in flight -> out_valid=0 the next cycle, the discarded beats never appear, and a new beat emerges after 3 cycles.
REQ-037 With BARREL_ROTATOR_ZERO_FLAG_EN defined: SHR 0x01 by 1 -> a_out=0x00 and zero_out=1; ROTR 0x01 by 1 -> 0x80 and zero_out=0.

Source files
------------

// File: rtl/barrel_rotator_pipe.sv
// barrel_rotator_pipe
//   Pipelined log-stage barrel rotator/shifter. Stage k conditionally applies a
//   shift of 2^k (selected by shift bit k). Each stage has its own register
//   bank, so a beat takes SHIFT_BITS cycles from acceptance to out_valid.
//   The whole pipeline advances in lockstep. It freezes when enable is low or
//   when the final stage holds a result that downstream has not taken.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   enable               global advance enable (low freezes everything)
//   in_valid / in_ready  input beat handshake (in_ready == advance)
//   mode                 00 ROTR, 01 ROTL, 10 SHR logical, 11 SAR arithmetic
//   a_in, shift_in       operand and shift amount (0..DATA_WIDTH-1)
//   out_valid/out_ready  result beat handshake
//   a_out                result, taken from the final stage register
//   zero_out             (BARREL_ROTATOR_ZERO_FLAG_EN only) high iff a valid
//                        result is all zeros
//
// Configuration macro: BARREL_ROTATOR_ZERO_FLAG_EN
module barrel_rotator_pipe #(
  parameter int DATA_WIDTH = 256,
  parameter int SHIFT_BITS = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [SHIFT_BITS-1:0] shift_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] a_out
`ifdef BARREL_ROTATOR_ZERO_FLAG_EN
  ,
  output logic                  zero_out
`endif
);

  localparam logic [1:0] MODE_ROTR = 2'b00;
  localparam logic [1:0] MODE_ROTL = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;

  // Per-stage state. sgn carries the operand's original MSB for SAR fill,
  // because the in-flight data MSB changes as shifting proceeds.
  logic [SHIFT_BITS-1:0]                 vld_q,  vld_d;
  logic [SHIFT_BITS-1:0][1:0]            mode_q, mode_d;
  logic [SHIFT_BITS-1:0][SHIFT_BITS-1:0] sh_q,   sh_d;
  logic [SHIFT_BITS-1:0]                 sgn_q,  sgn_d;
  logic [SHIFT_BITS-1:0][DATA_WIDTH-1:0] data_q, data_d;

  // Stage input selection, walked stage by stage in the comb block.
  logic                  s_v;
  logic [1:0]            s_m;
  logic [SHIFT_BITS-1:0] s_sh;
  logic                  s_sg;
  logic [DATA_WIDTH-1:0] s_d;

  logic adv;

  // One stage's operation for a fixed power-of-two amount n (< DATA_WIDTH).
  function automatic logic [DATA_WIDTH-1:0] step(
    input logic [DATA_WIDTH-1:0] d,
    input logic [1:0]            m,
    input logic                  sgn,
    input int                    n
  );
    logic [DATA_WIDTH-1:0] fill;
    fill = ~({DATA_WIDTH{1'b1}} >> n);  // top n bits set
    case (m)
      MODE_ROTR: step = (d >> n) | (d << (DATA_WIDTH - n));
      MODE_ROTL: step = (d << n) | (d >> (DATA_WIDTH - n));
      MODE_SHR:  step = d >> n;
      default:   step = (d >> n) | (sgn ? fill : '0);
    endcase
  endfunction

  // Reset gates advance so in_ready is low during reset.
  assign adv       = rst_n && enable && (!out_valid || out_ready);
  assign in_ready  = adv;
  assign out_valid = vld_q[SHIFT_BITS-1];
  assign a_out     = data_q[SHIFT_BITS-1];

  always_comb begin
    s_v  = in_valid;
    s_m  = mode;
    s_sh = shift_in;
    s_sg = a_in[DATA_WIDTH-1];
    s_d  = a_in;
    for (int k = 0; k < SHIFT_BITS; k++) begin
      vld_d[k]  = s_v;
      mode_d[k] = s_m;
      sh_d[k]   = s_sh;
      sgn_d[k]  = s_sg;
      data_d[k] = s_sh[k] ? step(s_d, s_m, s_sg, 1 << k) : s_d;
      s_v  = vld_q[k];
      s_m  = mode_q[k];
      s_sh = sh_q[k];
      s_sg = sgn_q[k];
      s_d  = data_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q  <= vld_d;
      mode_q <= mode_d;
      sh_q   <= sh_d;
      sgn_q  <= sgn_d;
      data_q <= data_d;
    end
  end

`ifdef BARREL_ROTATOR_ZERO_FLAG_EN
  // Loaded with the final stage so it always matches a_out/out_valid.
  logic zero_q, zero_d;

  always_comb begin
    zero_d = vld_d[SHIFT_BITS-1] && (data_d[SHIFT_BITS-1] == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)   zero_q <= 1'b0;
    else if (adv) zero_q <= zero_d;
  end

  assign zero_out = zero_q;
`endif

endmodule

// File: tb/tb_barrel_rotator_pipe.sv
// Bench for barrel_rotator_pipe at DATA_WIDTH=8 (latency 3). Inputs are driven
// at the falling edge; registered outputs are sampled at the falling edge
// before driving, and in_ready is sampled 1 time unit after driving.
module tb_barrel_rotator_pipe;
  localparam int W = 8;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] a_in = '0;
  logic [S-1:0] shift_in = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] a_out;
`ifdef BARREL_ROTATOR_ZERO_FLAG_EN
  logic         zero_out;
`endif

  int n_vec = 0;
  int n_err = 0;

  barrel_rotator_pipe #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .a_in(a_in), .shift_in(shift_in),
    .out_valid(out_valid), .out_ready(out_ready), .a_out(a_out)
`ifdef BARREL_ROTATOR_ZERO_FLAG_EN
    , .zero_out(zero_out)
`endif
  );

  always #5 clk = ~clk;

  // Reference: bitwise definition of each operation.
  function automatic logic [W-1:0] ref_op(input logic [1:0] m, input logic [W-1:0] a, input int n);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      case (m)
        2'd0:    r[i] = a[(i + n) % W];
        2'd1:    r[i] = a[(i - n + W) % W];
        2'd2:    r[i] = (i + n < W) ? a[i + n] : 1'b0;
        default: r[i] = (i + n < W) ? a[i + n] : a[W-1];
      endcase
    end
    return r;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    a_in = 8'hA5; shift_in = 3'd2; mode = 2'd0;
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_directed;
    logic [1:0]   ms [13] = '{0, 1, 2, 3, 3, 0, 1, 2, 3, 3, 0, 1, 2};
    logic [W-1:0] as [13] = '{8'h81, 8'h81, 8'h80, 8'h80, 8'h70, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h80, 8'h01, 8'h80, 8'hFF};
    int           ns [13] = '{1, 1, 3, 3, 3, 0, 0, 0, 0, 7, 7, 7, 7};
    logic [W-1:0] es [13] = '{8'hC0, 8'h03, 8'h10, 8'hF0, 8'h0E, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'hFF, 8'h02, 8'h40, 8'h01};
    for (int v = 0; v < 13; v++) begin
      int lat;
      logic [W-1:0] got;
      lat = 0; got = '0;
      enable = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
      mode = ms[v]; a_in = as[v]; shift_in = S'(ns[v]);
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL dir_in_ready[%0d] got %b want 1", v, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      for (int j = 1; j <= 8; j++) begin
        if (lat == 0 && out_valid === 1'b1) begin lat = j; got = a_out; end
        @(negedge clk);
      end
      n_vec++;
      if (lat != 3) begin n_err++; $display("FAIL dir_latency[%0d] got %0d want 3", v, lat); end
      n_vec++;
      if (got !== es[v]) begin n_err++; $display("FAIL dir_result[%0d] got %h want %h", v, got, es[v]); end
    end
  endtask

  // Random traffic with random stalls, enable drops and modes.
  task automatic test_back_to_back;
    logic [W-1:0] q[$];
    logic         ov, hold_prev, exp_rdy;
    logic [W-1:0] ao, prev_ao, e;
    hold_prev = 1'b0; prev_ao = '0;
    for (int c = 0; c < 420; c++) begin
      ov = out_valid; ao = a_out;
      if (hold_prev) begin
        n_vec++;
        if (ov !== 1'b1 || ao !== prev_ao) begin
          n_err++; $display("FAIL rnd_hold cyc %0d got v=%b d=%h want v=1 d=%h", c, ov, ao, prev_ao);
        end
      end
      if (c < 400) begin
        enable    = ($urandom % 8) != 0;
        out_ready = ($urandom % 3) != 0;
        in_valid  = ($urandom % 4) != 0;
      end else begin
        enable = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
      end
      mode = 2'($urandom); a_in = W'($urandom); shift_in = S'($urandom);
      #1;
      exp_rdy = enable && (!ov || out_ready);
      n_vec++;
      if (in_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", c, in_ready, exp_rdy); end
      if (ov && out_ready && enable) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rnd_spurious cyc %0d got %h want none", c, ao);
        end else begin
          e = q.pop_front();
          if (ao !== e) begin n_err++; $display("FAIL rnd_data cyc %0d got %h want %h", c, ao, e); end
        end
      end
      if (in_valid && in_ready) q.push_back(ref_op(mode, a_in, int'(shift_in)));
      hold_prev = ov && !(out_ready && enable);
      prev_ao = ao;
      @(negedge clk);
    end
    n_vec++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL rnd_drain got %0d pending v=%b want 0 pending v=0", q.size(), out_valid);
    end
  endtask

  task automatic test_stall;
    logic [W-1:0] exp_r [3];
    enable = 1'b1;
    for (int b = 0; b < 3; b++) begin
      out_ready = 1'b0; in_valid = 1'b1;
      mode = 2'($urandom); a_in = W'($urandom); shift_in = S'($urandom);
      exp_r[b] = ref_op(mode, a_in, int'(shift_in));
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_fill_rdy[%0d] got %b want 1", b, in_ready); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int h = 0; h < 5; h++) begin
      out_ready = 1'b0;
      #1;
      n_vec++;
      if (out_valid !== 1'b1 || a_out !== exp_r[0] || in_ready !== 1'b0) begin
        n_err++; $display("FAIL stall_hold[%0d] got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
                          h, out_valid, a_out, in_ready, exp_r[0]);
      end
      @(negedge clk);
    end
    for (int b = 0; b < 3; b++) begin
      out_ready = 1'b1;
      n_vec++;
      if (out_valid !== 1'b1 || a_out !== exp_r[b]) begin
        n_err++; $display("FAIL stall_release[%0d] got v=%b d=%h want v=1 d=%h", b, out_valid, a_out, exp_r[b]);
      end
      @(negedge clk);
    end
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_empty got %b want 0", out_valid); end
  endtask

  task automatic test_enable;
    logic [W-1:0] q[$];
    logic         ov, prev_ov, prev_en;
    logic [W-1:0] ao, prev_ao, e;
    logic [1:0]   bm;
    logic [W-1:0] ba;
    logic [S-1:0] bs;
    int           sent, rcvd;
    sent = 0; rcvd = 0; prev_en = 1'b1; prev_ov = 1'b0; prev_ao = '0;
    bm = 2'($urandom); ba = W'($urandom); bs = S'($urandom);
    for (int c = 0; c < 18; c++) begin
      ov = out_valid; ao = a_out;
      if (!prev_en) begin
        n_vec++;
        if (ov !== prev_ov || ao !== prev_ao) begin
          n_err++; $display("FAIL en_frozen cyc %0d got v=%b d=%h want v=%b d=%h", c, ov, ao, prev_ov, prev_ao);
        end
      end
      enable = !(c >= 3 && c < 7);
      out_ready = 1'b1;
      in_valid = (sent < 6);
      mode = bm; a_in = ba; shift_in = bs;
      #1;
      n_vec++;
      if (in_ready !== enable) begin n_err++; $display("FAIL en_in_ready cyc %0d got %b want %b", c, in_ready, enable); end
      if (ov && enable) begin
        n_vec++; rcvd++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL en_spurious cyc %0d got %h want none", c, ao);
        end else begin
          e = q.pop_front();
          if (ao !== e) begin n_err++; $display("FAIL en_data cyc %0d got %h want %h", c, ao, e); end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_op(bm, ba, int'(bs)));
        sent++;
        bm = 2'($urandom); ba = W'($urandom); bs = S'($urandom);
      end
      prev_en = enable; prev_ov = ov; prev_ao = ao;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_vec++;
    if (rcvd != 6 || q.size() != 0) begin
      n_err++; $display("FAIL en_count got %0d results want 6", rcvd);
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] ex;
    int           lat;
    logic [W-1:0] got;
    enable = 1'b1; out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1; mode = 2'd0; a_in = 8'h11 << b; shift_in = 3'd1;
      @(negedge clk);
    end
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
    in_valid = 1'b1; mode = 2'd3; a_in = 8'h96; shift_in = 3'd2;
    ex = ref_op(mode, a_in, 2);
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_accept got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0; got = '0;
    for (int j = 1; j <= 8; j++) begin
      if (lat == 0 && out_valid === 1'b1) begin lat = j; got = a_out; end
      @(negedge clk);
    end
    n_vec++;
    if (lat != 3 || got !== ex) begin
      n_err++; $display("FAIL rmid_new_beat got lat=%0d d=%h want lat=3 d=%h", lat, got, ex);
    end
  endtask

`ifdef BARREL_ROTATOR_ZERO_FLAG_EN
  task automatic test_zero_flag;
    logic [1:0]   ms [2] = '{2'd2, 2'd0};
    logic [W-1:0] es [2] = '{8'h00, 8'h80};
    logic         zs [2] = '{1'b1, 1'b0};
    for (int v = 0; v < 2; v++) begin
      enable = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
      mode = ms[v]; a_in = 8'h01; shift_in = 3'd1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || a_out !== es[v] || zero_out !== zs[v]) begin
        n_err++; $display("FAIL zero_flag[%0d] got v=%b d=%h z=%b want v=1 d=%h z=%b",
                          v, out_valid, a_out, zero_out, es[v], zs[v]);
      end
      @(negedge clk);
      n_vec++;
      if (zero_out !== 1'b0) begin n_err++; $display("FAIL zero_idle[%0d] got %b want 0", v, zero_out); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_enable();
    test_reset_mid();
`ifdef BARREL_ROTATOR_ZERO_FLAG_EN
    test_zero_flag();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
